// File: rtl/fpu_issue_if.sv
// Issue/writeback bundle between an FP op source and the FPU issue sequencer.
// The slave side is the sequencer; the master side is whoever feeds ops and
// supplies the arithmetic unit results.
interface fpu_issue_if #(
    parameter int TAG_W  = 5,
    parameter int MAXLAT = 16
);
    localparam int CNT_W = $clog2(MAXLAT + 1);

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_op;
    logic [TAG_W-1:0]     in_tag;
    logic [12:0]          unit_start;
    logic [13*32-1:0]     unit_res;
    logic                 wb_valid;
    logic [TAG_W-1:0]     wb_tag;
    logic [3:0]           wb_op;
    logic [31:0]          wb_data;
    logic                 wb_illegal;
    logic                 busy_div;
    logic                 busy_sqrt;
    logic [CNT_W-1:0]     inflight;
    logic                 idle;

    modport master (
        output flush, in_valid, in_op, in_tag, unit_res,
        input  in_ready, unit_start, wb_valid, wb_tag, wb_op, wb_data,
               wb_illegal, busy_div, busy_sqrt, inflight, idle
    );

    modport slave (
        input  flush, in_valid, in_op, in_tag, unit_res,
        output in_ready, unit_start, wb_valid, wb_tag, wb_op, wb_data,
               wb_illegal, busy_div, busy_sqrt, inflight, idle
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/writeback sequencer. Every accepted op reserves the writeback
// port for the exact cycle it will complete by being placed in a shift
// register at its latency depth; slot 1 feeds the registered writeback port.
// Iterative units (div/sqrt when not pipelined) are additionally blocked
// while an op of theirs is in flight.
module fpu_issue_ctrl #(
    parameter int TAG_W     = 5,
    parameter int LAT_ADD   = 3,
    parameter int LAT_MUL   = 3,
    parameter int LAT_DIV   = 10,
    parameter int LAT_SQRT  = 8,
    parameter int DIV_PIPE  = 0,
    parameter int SQRT_PIPE = 0,
    parameter int MAXLAT    = 16
) (
    input logic        clk,
    input logic        rst,
    fpu_issue_if.slave bus
);
    localparam int LW    = $clog2(MAXLAT + 2);
    localparam int CNT_W = $clog2(MAXLAT + 1);

    function automatic logic [LW-1:0] op_lat(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: op_lat = LW'(LAT_ADD);
            4'd2:       op_lat = LW'(LAT_MUL);
            4'd3:       op_lat = LW'(LAT_DIV);
            4'd4:       op_lat = LW'(LAT_SQRT);
            default:    op_lat = LW'(1);
        endcase
    endfunction

    // Reservation slots 1..MAXLAT; slot i completes i cycles from now.
    logic [MAXLAT:1]  slot_v;
    logic [TAG_W-1:0] slot_tag [1:MAXLAT];
    logic [3:0]       slot_op  [1:MAXLAT];

    logic             vld_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [3:0]       op_p1;
    logic             illegal_p1;
    logic             busy_div_q;
    logic             busy_sqrt_q;
    logic [CNT_W-1:0] inflight_q;

    logic [LW-1:0]     lat;
    logic [MAXLAT+1:0] v_ext;
    logic              slot_hit;
    logic              div_wb_now;
    logic              sqrt_wb_now;
    logic              div_block;
    logic              sqrt_block;
    logic              ready;
    logic              accept;
    logic [12:0]       start_vec;
    logic [31:0]       wb_data_c;

    // Issue decision: writeback-slot conflict and iterative-unit occupancy.
    // A busy iterative unit frees up on the edge its op moves to writeback,
    // so a same-unit op can be accepted on that very edge.
    always_comb begin
        lat         = op_lat(bus.in_op);
        v_ext       = {1'b0, slot_v, 1'b0};
        slot_hit    = v_ext[lat + LW'(1)];
        div_wb_now  = slot_v[1] && (slot_op[1] == 4'd3);
        sqrt_wb_now = slot_v[1] && (slot_op[1] == 4'd4);
        div_block   = (DIV_PIPE == 0) && (bus.in_op == 4'd3) && busy_div_q && !div_wb_now;
        sqrt_block  = (SQRT_PIPE == 0) && (bus.in_op == 4'd4) && busy_sqrt_q && !sqrt_wb_now;
        ready       = !rst && !bus.flush && !slot_hit && !div_block && !sqrt_block;
        accept      = bus.in_valid && ready;
        start_vec   = '0;
        if (accept && (bus.in_op < 4'd13)) begin
            start_vec[bus.in_op] = 1'b1;
        end
    end

    // Shift the reservation register and drop the accepted op at its depth.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            slot_v <= '0;
            for (int i = 1; i <= MAXLAT; i++) begin
                slot_tag[i] <= '0;
                slot_op[i]  <= '0;
            end
        end else begin
            for (int i = 1; i < MAXLAT; i++) begin
                slot_v[i]   <= slot_v[i+1];
                slot_tag[i] <= slot_tag[i+1];
                slot_op[i]  <= slot_op[i+1];
            end
            slot_v[MAXLAT]   <= 1'b0;
            slot_tag[MAXLAT] <= '0;
            slot_op[MAXLAT]  <= '0;
            if (accept) begin
                slot_v[lat]   <= 1'b1;
                slot_tag[lat] <= bus.in_tag;
                slot_op[lat]  <= bus.in_op;
            end
        end
    end

    // Register slot 1 onto the writeback port.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            vld_p1     <= 1'b0;
            tag_p1     <= '0;
            op_p1      <= '0;
            illegal_p1 <= 1'b0;
        end else begin
            vld_p1     <= slot_v[1];
            tag_p1     <= slot_tag[1];
            op_p1      <= slot_op[1];
            illegal_p1 <= slot_v[1] && (slot_op[1] >= 4'd13);
        end
    end

    // Iterative unit occupancy: set on accept, released as the op writes back.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            busy_div_q  <= 1'b0;
            busy_sqrt_q <= 1'b0;
        end else begin
            if (DIV_PIPE == 0) begin
                if (accept && (bus.in_op == 4'd3)) busy_div_q <= 1'b1;
                else if (div_wb_now)               busy_div_q <= 1'b0;
            end
            if (SQRT_PIPE == 0) begin
                if (accept && (bus.in_op == 4'd4)) busy_sqrt_q <= 1'b1;
                else if (sqrt_wb_now)              busy_sqrt_q <= 1'b0;
            end
        end
    end

    // In-flight count: accepted ops not yet seen on the writeback port.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            inflight_q <= '0;
        end else if (accept && !vld_p1) begin
            inflight_q <= inflight_q + CNT_W'(1);
        end else if (!accept && vld_p1) begin
            inflight_q <= inflight_q - CNT_W'(1);
        end
    end

    // Select the completing unit's result; illegal or idle port reads 0.
    always_comb begin
        wb_data_c = '0;
        for (int k = 0; k < 13; k++) begin
            if (vld_p1 && (op_p1 == 4'(k))) begin
                wb_data_c = bus.unit_res[k*32 +: 32];
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.unit_start = start_vec;
    assign bus.wb_valid   = vld_p1;
    assign bus.wb_tag     = tag_p1;
    assign bus.wb_op      = op_p1;
    assign bus.wb_data    = wb_data_c;
    assign bus.wb_illegal = illegal_p1;
    assign bus.busy_div   = busy_div_q;
    assign bus.busy_sqrt  = busy_sqrt_q;
    assign bus.inflight   = inflight_q;
    assign bus.idle       = (inflight_q == '0);
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Parametrised issue/writeback sequencer for the FPU.
- Accepts one FP op per cycle over a valid/ready handshake and drives start strobes to the arithmetic units.
- Tracks every in-flight op in a completion-reservation shift register, so pipelined units can overlap and iterative units are blocked while busy.
- Returns a tagged result on a single writeback port with no port collisions; replaces the one-op-at-a-time state counter.

Parameters:
- TAG_W, 5, width of the op tag carried from issue to writeback.
- LAT_ADD, 3, fadd/fsub latency in cycles, 1..MAXLAT.
- LAT_MUL, 3, fmul latency, 1..MAXLAT.
- LAT_DIV, 10, fdiv latency, 1..MAXLAT.
- LAT_SQRT, 8, fsqrt latency, 1..MAXLAT.
- DIV_PIPE, 0, 1 = fdiv accepts a new op every cycle; 0 = iterative, one op at a time.
- SQRT_PIPE, 0, same as DIV_PIPE for fsqrt.
- MAXLAT, 16, depth of the reservation register. Must be ≥ every LAT_*.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all in-flight ops; synchronous
- in_valid  in  1  op request
- in_ready  out  1  op accepted this cycle when in_valid && in_ready
- in_op  in  4  0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5 sgnj, 6 sgnjn, 7 sgnjx, 8 eq, 9 le, 10 lt, 11 cvt.w.s, 12 cvt.s.w, 13-15 illegal
- in_tag  in  TAG_W  op tag
- unit_start  out  13  one-hot start, bit = in_op, asserted only on the accept cycle
- unit_res  in  13*32  flattened unit results, slice k = op k
- wb_valid  out  1  writeback strobe
- wb_tag  out  TAG_W  tag of the completing op
- wb_op  out  4  op of the completing op
- wb_data  out  32  unit_res slice wb_op; 0 when wb_op is illegal
- wb_illegal  out  1  completing op was 13-15
- busy_div  out  1  iterative fdiv occupied
- busy_sqrt  out  1  iterative fsqrt occupied
- inflight  out  $clog2(MAXLAT+1)  count of accepted, not-yet-written-back ops
- idle  out  1  inflight == 0

Behaviour:
- Latency L(op): add/sub → LAT_ADD; mul → LAT_MUL; div → LAT_DIV; sqrt → LAT_SQRT; ops 5-15 → 1.
- Reservation register: slots 1..MAXLAT, each holding {v, tag, op}.
  - Every cycle: slot[i] ← slot[i+1]; slot[MAXLAT] ← empty.
  - Slot[1] content is registered onto wb_valid/wb_tag/wb_op the next edge.
- Accept at edge t writes slot[L] (post-shift). wb_valid is high in the cycle starting at edge t+L, for exactly one cycle.
- in_ready = !rst && !flush && !cur_slot[L+1].v && !(iterative unit for in_op busy). For L = MAXLAT, cur_slot[L+1] is treated as empty.
  - in_ready depends on in_op, combinationally. in_valid must not depend on in_ready.
- Iterative unit:
  - busy set on accept.
  - busy cleared on the edge that raises wb_valid for that op.
  - A same-unit op presented in that wb cycle is accepted.
- inflight: +1 on accept, −1 on wb_valid. Both in the same cycle → unchanged.
- wb_data is a combinational mux of unit_res by wb_op. Units must present results exactly L cycles after their start strobe.
- Ops are not reordered per unit. Cross-unit completion order follows latency, not issue order.
- flush: clears all slots, busy flags, inflight and wb_valid on the next edge. No writeback occurs for any op in flight at the flush edge. A wb_valid already high in the flush cycle still counts as delivered.
- rst: same clearing as flush, and in_ready = 0 while rst is high.
- Reset values: wb_valid 0, wb_tag 0, wb_op 0, wb_data 0 (since wb_op = 0 with unit_res slice ignored → drive 0 while !wb_valid), wb_illegal 0, busy_* 0, inflight 0, idle 1, unit_start 0.
- Illegal op: accepted; unit_start all 0; completes after 1 cycle with wb_illegal = 1, wb_data = 0.

Test Plan:
- Defaults, rst released, single add tag 3 at edge t → unit_start = 0x0001 at t; wb_valid at t+3 with wb_tag 3, wb_data = unit_res[31:0]; inflight 1→0; idle returns to 1.
- Back-to-back mul tags 1,2,3 on consecutive cycles → all accepted with in_ready held 1; wb_valid on 3 consecutive cycles, tags 1,2,3.
- div tag 4 at t, then div tag 5 held valid → in_ready 0 until edge t+10; tag 5 accepted at t+10; busy_div high t..t+20; writebacks at t+10 and t+20.
- Collision: add (L=3) at t, then sgnj (L=1) presented at t+2 → in_ready 0 at t+2 (slot conflict); accepted at t+3; wb tags in order add at t+3, sgnj at t+4.
- sqrt tag 7 at t, flush at t+4 → no wb_valid through t+12; busy_sqrt 0 and inflight 0 after edge t+5; a new sqrt accepted at t+5.
- Illegal op 14 tag 9 → accepted, unit_start 0, wb_valid one cycle later with wb_illegal 1, wb_data 0; rst asserted mid-stream with 3 ops in flight → all outputs at reset values next edge, no later wb_valid.
